alu_iter: RTL and testbench

Parametrised, multi-cycle successor to the datapath ALU. Keeps the existing 4-bit operation codes and adds an iterative multiplier and an optional iterative divider, both at a configurable word width. Sits in the execute stage behind a valid/ready handshake so that the control unit can stall on long operations. Fixes the zero-flag definition: `zero` means "result is zero" and nothing else.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_iter_if.sv | 28 ++
 rtl/alu_iter_muldiv.sv | 154 +++++++++++++++
 rtl/alu_iter.sv | 135 +++++++++++++
 tb/tb_alu_iter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the iterative ALU.
//   alu_ctl_e   - operation codes (values match the legacy datapath ALU)
//   alu_state_e - FSM state encoding used by alu_iter
//   alu_is_iter - 1 when a code goes through the multi-cycle engine
// Macro ALU_ITER_DIV_EN: when defined, div/rem are multi-cycle operations.
// When it is not defined they are treated as unknown single-cycle codes.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SLL  = 4'd3,
    ALU_SUB  = 4'd6,
    ALU_SLT  = 4'd7,
    ALU_MUL  = 4'd8,
    ALU_MULH = 4'd9,
    ALU_DIV  = 4'd10,
    ALU_REM  = 4'd11,
    ALU_NOR  = 4'd12,
    ALU_XOR  = 4'd13
  } alu_ctl_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  function automatic logic alu_is_iter(input logic [3:0] ctl);
`ifdef ALU_ITER_DIV_EN
    return (ctl == ALU_MUL) || (ctl == ALU_MULH) ||
           (ctl == ALU_DIV) || (ctl == ALU_REM);
`else
    return (ctl == ALU_MUL) || (ctl == ALU_MULH);
`endif
  endfunction

endpackage

// File: rtl/alu_iter_if.sv
// alu_iter_if: request/response handshake bundle for alu_iter.
//   in_valid/in_ready  - request handshake; ctl, a, b travel with it
//   out_valid/out_ready - response handshake; out, zero, ovf travel with it
// master: the requester/consumer side. slave: the ALU side.
interface alu_iter_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       ctl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, ctl, a, b, out_ready,
    input  in_ready, out_valid, out, zero, ovf
  );

  modport slave (
    input  in_valid, ctl, a, b, out_ready,
    output in_ready, out_valid, out, zero, ovf
  );
endinterface

// File: rtl/alu_iter_muldiv.sv
// alu_iter_muldiv: iterative multiply (radix-2 shift-add) and, when
// ALU_ITER_DIV_EN is defined, restoring divide, both on operand magnitudes
// with the sign applied to the final step.
// Ports:
//   clk, rst_n      - clock, async active-low reset
//   start           - one-cycle pulse; captures ctl/a/b and loads the counter
//   ctl, a, b       - operation and operands (sampled only on start)
//   done            - one-cycle pulse; result/ovf are valid in that cycle
//   result, ovf     - signed-corrected result and div overflow flag
// The counter loads WIDTH on start; the final step is taken combinationally
// in the cycle where the counter reads 1, so done comes WIDTH cycles after
// start and the counter is back at 0 when the engine goes idle.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0]      cnt;
  logic [3:0]         op_q;
  logic               neg_q;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH:0]   prod_q;
  logic [2*WIDTH:0]   prod_nxt;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_fix;

  assign mag_a = a[WIDTH-1] ? -a : a;
  assign mag_b = b[WIDTH-1] ? -b : b;

  // Upper half carries one extra bit so the add never loses its carry.
  assign mul_sum  = prod_q[2*WIDTH:WIDTH] + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_nxt = {1'b0, mul_sum, prod_q[WIDTH-1:1]};
  assign prod_mag = prod_nxt[2*WIDTH-1:0];
  assign prod_fix = neg_q ? -prod_mag : prod_mag;

  assign done = (cnt == CNT_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else if (start) begin
      cnt     <= CNT_LOAD;
      op_q    <= ctl;
      neg_q   <= a[WIDTH-1] ^ b[WIDTH-1];
      mcand_q <= mag_a;
      prod_q  <= {{(WIDTH+1){1'b0}}, mag_b};
    end else if (cnt != '0) begin
      cnt    <= cnt - CNT_ONE;
      prod_q <= prod_nxt;
    end
  end

`ifdef ALU_ITER_DIV_EN
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] a_q;
  logic             a_neg_q;
  logic             div0_q;
  logic             minneg_q;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // Partial remainder stays below the divisor, so WIDTH bits hold it and
  // the shifted trial value needs only one more.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign ge      = (shifted >= {1'b0, dvs_q});
  assign rem_nxt = ge ? WIDTH'(shifted - {1'b0, dvs_q}) : shifted[WIDTH-1:0];
  assign quo_nxt = {quo_q[WIDTH-2:0], ge};
  assign quo_fix = neg_q ? -quo_nxt : quo_nxt;
  assign rem_fix = a_neg_q ? -rem_nxt : rem_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      a_q      <= '0;
      a_neg_q  <= 1'b0;
      div0_q   <= 1'b0;
      minneg_q <= 1'b0;
    end else if (start) begin
      quo_q    <= mag_a;
      rem_q    <= '0;
      dvs_q    <= mag_b;
      a_q      <= a;
      a_neg_q  <= a[WIDTH-1];
      div0_q   <= (b == '0);
      minneg_q <= (a == {1'b1, {(WIDTH-1){1'b0}}}) && (&b);
    end else if (cnt != '0) begin
      quo_q <= quo_nxt;
      rem_q <= rem_nxt;
    end
  end
`endif

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (op_q)
      ALU_MUL:  result = prod_fix[WIDTH-1:0];
      ALU_MULH: result = prod_fix[2*WIDTH-1:WIDTH];
`ifdef ALU_ITER_DIV_EN
      ALU_DIV: begin
        if (div0_q) begin
          result = '1;
        end else if (minneg_q) begin
          result = {1'b1, {(WIDTH-1){1'b0}}};
          ovf    = 1'b1;
        end else begin
          result = quo_fix;
        end
      end
      ALU_REM: begin
        if (div0_q) begin
          result = a_q;
        end else if (minneg_q) begin
          ovf = 1'b1;
        end else begin
          result = rem_fix;
        end
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_iter.sv
// alu_iter: multi-cycle execute-stage ALU behind a valid/ready handshake.
// Single-cycle ops are computed here; mul/mulh (and div/rem when
// ALU_ITER_DIV_EN is defined) are handed to alu_iter_muldiv.
// Ports:
//   clk, rst_n - clock, async active-low reset
//   bus        - alu_iter_if.slave: in_valid/in_ready/ctl/a/b request,
//                out_valid/out_ready/out/zero/ovf registered response
// States:
//   IDLE | ready for a request (in_ready high)
//   CALC | iterative engine running, waiting for its done pulse
//   DONE | result held on out/zero/ovf until out_ready
module alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  alu_iter_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] CALC = ST_CALC;
  localparam logic [1:0] DONE = ST_DONE;

  logic [1:0]       state;
  logic             in_ready;
  logic             accept;
  logic             iter_req;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] dif;
  logic [WIDTH-1:0] res_c;
  logic             ovf_c;
  logic             eng_done;
  logic             eng_ovf;
  logic [WIDTH-1:0] eng_res;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_q;
  logic             zero_q;
  logic             ovf_q;

  assign in_ready = (state == IDLE);
  assign accept   = bus.in_valid && in_ready;
  assign iter_req = alu_is_iter(bus.ctl);

  assign sum = bus.a + bus.b;
  assign dif = bus.a - bus.b;

  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    case (bus.ctl)
      ALU_ADD: begin
        res_c = sum;
        ovf_c = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      ALU_SUB: begin
        res_c = dif;
        ovf_c = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif[WIDTH-1] != bus.a[WIDTH-1]);
      end
      ALU_AND: res_c = bus.a & bus.b;
      ALU_OR:  res_c = bus.a | bus.b;
      ALU_NOR: res_c = ~(bus.a | bus.b);
      ALU_XOR: res_c = bus.a ^ bus.b;
      ALU_SLL: res_c = bus.a << bus.b[SHW-1:0];
      ALU_SLT: res_c = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      default: ;
    endcase
  end

  alu_iter_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && iter_req),
    .ctl    (bus.ctl),
    .a      (bus.a),
    .b      (bus.b),
    .done   (eng_done),
    .result (eng_res),
    .ovf    (eng_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (iter_req) begin
              state <= CALC;
            end else begin
              state       <= DONE;
              out_valid_q <= 1'b1;
              out_q       <= res_c;
              zero_q      <= (res_c == '0);
              ovf_q       <= ovf_c;
            end
          end
        end
        CALC: begin
          if (eng_done) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            out_q       <= eng_res;
            zero_q      <= (eng_res == '0);
            ovf_q       <= eng_ovf;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.zero      = zero_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_alu_iter.sv
module tb_alu_iter;
  import alu_pkg::*;

  typedef struct packed {
    logic [3:0]  c;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] e;
    logic        v;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   busy_ready;

  alu_iter_if #(.WIDTH(32)) b32 ();
  alu_iter_if #(.WIDTH(8))  b8 ();

  alu_iter #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
  alu_iter #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue32(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                         output int lat);
    b32.ctl = c; b32.a = x; b32.b = y; b32.in_valid = 1'b1;
    @(posedge clk); #1;
    // scramble inputs after accept: the DUT must use the captured values
    b32.in_valid = 1'b0; b32.ctl = ALU_ADD; b32.a = 32'hDEADBEEF; b32.b = 32'h12345678;
    lat = 1; busy_ready = 0;
    while (!b32.out_valid && lat < 200) begin
      if (b32.in_ready) busy_ready++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic issue8(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y,
                        output int lat);
    b8.ctl = c; b8.a = x; b8.b = y; b8.in_valid = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0; b8.a = 8'h5A; b8.b = 8'hA5;
    lat = 1; busy_ready = 0;
    while (!b8.out_valid && lat < 200) begin
      if (b8.in_ready) busy_ready++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic consume32();
    b32.out_ready = 1'b1;
    @(posedge clk); #1;
    b32.out_ready = 1'b0;
  endtask

  task automatic consume8();
    b8.out_ready = 1'b1;
    @(posedge clk); #1;
    b8.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (b32.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", b32.in_ready); end
    checks++; if (b32.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", b32.out_valid); end
    checks++; if (b32.out !== 32'h0) begin failures++; $display("FAIL reset_out got=%h exp=0", b32.out); end
    checks++; if (b32.zero !== 1'b0) begin failures++; $display("FAIL reset_zero got=%b exp=0", b32.zero); end
    checks++; if (b32.ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", b32.ovf); end
    checks++; if (b8.in_ready !== 1'b1 || b8.out !== 8'h0) begin failures++; $display("FAIL reset_w8 in_ready=%b out=%h exp 1/00", b8.in_ready, b8.out); end
  endtask

  task automatic run_vectors32(input string tag, input vec_t v[], input int exp_lat);
    int lat;
    foreach (v[i]) begin
      issue32(v[i].c, v[i].x, v[i].y, lat);
      checks++; if (b32.out !== v[i].e) begin failures++; $display("FAIL %s[%0d]_out ctl=%0d got=%h exp=%h", tag, i, v[i].c, b32.out, v[i].e); end
      checks++; if (b32.ovf !== v[i].v) begin failures++; $display("FAIL %s[%0d]_ovf got=%b exp=%b", tag, i, b32.ovf, v[i].v); end
      checks++; if (b32.zero !== (v[i].e == 32'h0)) begin failures++; $display("FAIL %s[%0d]_zero got=%b exp=%b", tag, i, b32.zero, (v[i].e == 32'h0)); end
      checks++; if (lat != exp_lat) begin failures++; $display("FAIL %s[%0d]_latency got=%0d exp=%0d", tag, i, lat, exp_lat); end
      checks++; if (busy_ready != 0) begin failures++; $display("FAIL %s[%0d]_in_ready_busy got=%0d cycles exp=0", tag, i, busy_ready); end
      consume32();
    end
  endtask

  task automatic test_single_cycle();
    vec_t v[] = new[14];
    v[0]  = '{ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1};
    v[1]  = '{ALU_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0};
    v[2]  = '{ALU_SLT, 32'hFFFFFFF6, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    v[3]  = '{ALU_SLT, 32'h0000000A, 32'h00000002, 32'h00000000, 1'b0};
    v[4]  = '{ALU_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1};
    v[5]  = '{ALU_AND, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
    v[6]  = '{ALU_OR,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0};
    v[7]  = '{ALU_NOR, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    v[8]  = '{ALU_XOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0};
    v[9]  = '{ALU_SLL, 32'h00000001, 32'h00000021, 32'h00000002, 1'b0};
    v[10] = '{4'd4,    32'h00000005, 32'h00000007, 32'h00000000, 1'b0};
    v[11] = '{ALU_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    v[12] = '{ALU_SLT, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0};
    v[13] = '{ALU_SUB, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    run_vectors32("single", v, 1);
  endtask

  task automatic test_mul();
    vec_t v[] = new[6];
    v[0] = '{ALU_MUL,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 1'b0};
    v[1] = '{ALU_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0};
    v[2] = '{ALU_MULH, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 1'b0};
    v[3] = '{ALU_MUL,  32'h00000000, 32'h00012345, 32'h00000000, 1'b0};
    v[4] = '{ALU_MUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0};
    v[5] = '{ALU_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    run_vectors32("mul", v, 33);
  endtask

`ifdef ALU_ITER_DIV_EN
  task automatic test_div();
    vec_t v[] = new[10];
    v[0] = '{ALU_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0};
    v[1] = '{ALU_REM, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 1'b0};
    v[2] = '{ALU_DIV, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 1'b0};
    v[3] = '{ALU_REM, 32'h00000005, 32'h00000000, 32'h00000005, 1'b0};
    v[4] = '{ALU_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1};
    v[5] = '{ALU_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    v[6] = '{ALU_DIV, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0};
    v[7] = '{ALU_REM, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    v[8] = '{ALU_DIV, 32'h00000064, 32'h00000007, 32'h0000000E, 1'b0};
    v[9] = '{ALU_REM, 32'h00000064, 32'h00000007, 32'h00000002, 1'b0};
    run_vectors32("div", v, 33);
  endtask
`else
  task automatic test_div_absent();
    vec_t v[] = new[2];
    v[0] = '{ALU_DIV, 32'h00000006, 32'h00000003, 32'h00000000, 1'b0};
    v[1] = '{ALU_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0};
    run_vectors32("nodiv", v, 1);
  endtask
`endif

  task automatic test_backpressure();
    int lat;
    int bad;
    issue32(ALU_ADD, 32'd1, 32'd2, lat);
    checks++; if (b32.out !== 32'd3 || lat != 1) begin failures++; $display("FAIL bp_first out=%h lat=%0d exp 3/1", b32.out, lat); end
    b32.ctl = ALU_SUB; b32.a = 32'd100; b32.b = 32'd1; b32.in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (b32.out !== 32'd3 || b32.out_valid !== 1'b1 || b32.in_ready !== 1'b0 || b32.zero !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold unstable_cycles=%0d exp=0", bad); end
    b32.out_ready = 1'b1;
    @(posedge clk); #1;
    b32.out_ready = 1'b0; b32.in_valid = 1'b0;
    checks++; if (b32.in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready_after got=%b exp=1", b32.in_ready); end
    checks++; if (b32.out_valid !== 1'b0) begin failures++; $display("FAIL bp_out_valid_after got=%b exp=0", b32.out_valid); end
    checks++; if (b32.out !== 32'd3) begin failures++; $display("FAIL bp_ignored_req out=%h exp=3", b32.out); end
  endtask

  task automatic test_back_to_back();
    int seen;
    b32.ctl = ALU_ADD; b32.a = 32'd1; b32.b = 32'd1; b32.in_valid = 1'b1; b32.out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (b32.out_valid === 1'b1) seen++;
    end
    b32.in_valid = 1'b0; b32.out_ready = 1'b0;
    checks++; if (seen != 5) begin failures++; $display("FAIL b2b_results got=%0d exp=5", seen); end
    checks++; if (b32.in_ready !== 1'b1 || b32.out !== 32'd2) begin failures++; $display("FAIL b2b_end in_ready=%b out=%h exp 1/2", b32.in_ready, b32.out); end
  endtask

  task automatic test_width8();
    int lat;
    int bad;
    issue8(ALU_MUL, 8'h0F, 8'h0F, lat);
    checks++; if (b8.out !== 8'hE1) begin failures++; $display("FAIL w8_mul_out got=%h exp=e1", b8.out); end
    checks++; if (lat != 9) begin failures++; $display("FAIL w8_mul_latency got=%0d exp=9", lat); end
    checks++; if (busy_ready != 0) begin failures++; $display("FAIL w8_in_ready_busy got=%0d exp=0", busy_ready); end
    b8.ctl = ALU_ADD; b8.a = 8'h01; b8.b = 8'h01; b8.in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (b8.out !== 8'hE1 || b8.out_valid !== 1'b1 || b8.in_ready !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL w8_hold unstable_cycles=%0d exp=0", bad); end
    b8.out_ready = 1'b1;
    @(posedge clk); #1;
    b8.out_ready = 1'b0; b8.in_valid = 1'b0;
    checks++; if (b8.in_ready !== 1'b1) begin failures++; $display("FAIL w8_in_ready_after got=%b exp=1", b8.in_ready); end
    issue8(ALU_MULH, 8'h80, 8'h80, lat);
    checks++; if (b8.out !== 8'h40 || lat != 9) begin failures++; $display("FAIL w8_mulh out=%h lat=%0d exp 40/9", b8.out, lat); end
    consume8();
  endtask

  task automatic test_reset_mid_calc();
    int lat;
    int bad;
    b32.ctl = ALU_MUL; b32.a = 32'd3; b32.b = 32'd5; b32.in_valid = 1'b1;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (b32.in_ready !== 1'b0 || b32.out !== 32'd2) begin failures++; $display("FAIL rst_calc_pre in_ready=%b out=%h exp 0/2", b32.in_ready, b32.out); end
    rst_n = 1'b0;
    #1;
    checks++; if (b32.in_ready !== 1'b1) begin failures++; $display("FAIL rst_calc_in_ready got=%b exp=1", b32.in_ready); end
    checks++; if (b32.out_valid !== 1'b0) begin failures++; $display("FAIL rst_calc_out_valid got=%b exp=0", b32.out_valid); end
    checks++; if (b32.out !== 32'h0) begin failures++; $display("FAIL rst_calc_out got=%h exp=0", b32.out); end
    checks++; if (b32.zero !== 1'b0 || b32.ovf !== 1'b0) begin failures++; $display("FAIL rst_calc_flags zero=%b ovf=%b exp 0/0", b32.zero, b32.ovf); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (b32.out_valid !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL rst_calc_stale_result cycles=%0d exp=0", bad); end
    issue32(ALU_ADD, 32'd4, 32'd5, lat);
    checks++; if (b32.out !== 32'd9 || lat != 1) begin failures++; $display("FAIL rst_calc_next out=%h lat=%0d exp 9/1", b32.out, lat); end
    consume32();
  endtask

  initial begin
    checks = 0; failures = 0; busy_ready = 0;
    rst_n = 1'b0;
    b32.in_valid = 1'b0; b32.ctl = 4'd0; b32.a = '0; b32.b = '0; b32.out_ready = 1'b0;
    b8.in_valid  = 1'b0; b8.ctl  = 4'd0; b8.a  = '0; b8.b  = '0; b8.out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    test_reset();
    test_single_cycle();
    test_mul();
`ifdef ALU_ITER_DIV_EN
    test_div();
`else
    test_div_absent();
`endif
    test_backpressure();
    test_back_to_back();
    test_width8();
    test_reset_mid_calc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
